uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver directly upstream of the UART command processor. It converts the asynchronous rx line (8N1, LSB first) into bytes. Each byte is delivered on the cmd_req/cmd_data/cmd_ack 4-phase handshake that the processor consumes. Two bytes of buffering cover processor handshake latency; framing and overrun errors are flagged as 1-cycle pulses for the error manager.

Parameters:
P_CLKS_PER_BIT, 100, clk cycles per bit period (100 MHz clk / 1 Mbaud); legal minimum 4.
P_CNT_W, 16, width of the bit-period counter; must hold P_CLKS_PER_BIT-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial input, idle high
cmd_req  out  1  byte available on cmd_data
cmd_data  out  8  received byte
cmd_ack  in  1  consumer acknowledge
frm_err  out  1  1-cycle pulse: stop bit sampled low, byte dropped
ovr_err  out  1  1-cycle pulse: byte completed with both buffers full, byte dropped

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low; every flop clears on assertion. All logic runs on posedge clk.
- Reset values: cmd_req=0, cmd_data=0, frm_err=0, ovr_err=0. Synchroniser flops reset to 1 (idle). Both FSMs reset to their idle states; hold buffer empty.
- Input: 2-FF synchroniser gives rx_s; fall = rx_s_d & !rx_s.
- Rx FSM:
  - S_IDLE: on fall, clear cnt and go to S_START. A line held low does not retrigger.
  - S_START: when cnt==P_CLKS_PER_BIT/2-1, sample. Sample 0: clear cnt and bit index, go to S_DATA. Sample 1 (glitch): go to S_IDLE, no output.
  - S_DATA: sample when cnt==P_CLKS_PER_BIT-1, then clear cnt. Shift the sample into bit[idx], LSB first. After idx 7, go to S_STOP.
  - S_STOP: sample at P_CLKS_PER_BIT-1. Sample 1: byte done, push to hold. Sample 0: frm_err pulses the next cycle and the byte is discarded. Either way go to S_IDLE.
- Hold buffer: one byte plus hold_vld.
  - Byte done with hold empty, or with hold being drained that same cycle: write hold, hold_vld=1 next cycle.
  - Byte done with hold full and not draining: ovr_err pulses; hold keeps the older byte.
- Handshake FSM:
  - H_IDLE: if hold_vld, set cmd_data<=hold, cmd_req<=1, clear hold_vld (drain), go to H_REQ.
  - H_REQ: cmd_req held until cmd_ack=1, then cmd_req<=0 and go to H_ACKLO.
  - H_ACKLO: cmd_data stays stable until cmd_ack=0, then go to H_IDLE.
  - cmd_data changes only in H_IDLE, so it is stable from cmd_req rise through ack fall.
- Latency: stop-bit sample at edge N gives hold_vld at N+1 and cmd_req high at N+2 when the handshake is idle.
- Buffering: effective depth is 2 (cmd_data register + hold). The 3rd un-acked byte overruns.
- Reset mid-frame or mid-handshake: immediate return to reset values. The partial byte is lost; the next complete frame is received normally.
- Counters: cnt saturates never; it is always cleared at each sample point.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: every sample (start, data, stop) is the 2-of-3 majority of rx_s at cnt target-1, target, and target+1. The state advance happens at target+1, and cnt restarts at 1 to keep period alignment. Rejects single-cycle glitches.
- Undefined: single sample at the target count.
- Frame timing is identical either way within ±1 clk.

Decomposition:
- Shared package uart_pkg:
  - Rx state encodings (S_IDLE, S_START, S_DATA, S_STOP).
  - Handshake states (H_IDLE, H_REQ, H_ACKLO).
  - Frame constants: 8 data bits, idle level 1.
- Sub-module uart_rx_sync: 2-FF synchroniser plus falling-edge detect, outputs rx_s and fall, asynchronous rst_n, resets to 1.

Test Plan:
- P_CLKS_PER_BIT=16. Serial 0xA5, bench acks 4-phase after 3 clks -> cmd_req rises 2 clks after the stop-bit mid-sample; cmd_data=0xA5 stable until ack low; exactly one byte delivered.
- 0x8F then 0xC7 back-to-back, ack withheld until after the second stop bit -> 0x8F then 0xC7 delivered in order; no ovr_err.
- 0x01, 0x02, 0x03 back-to-back, ack withheld -> 0x01 and 0x02 delivered; exactly one ovr_err pulse; 0x03 never appears.
- 0x55 with stop bit forced 0, then line high, then 0x12 -> one frm_err pulse; no cmd_req for 0x55; 0x12 delivered.
- rx low for 5 clks (< 8), then high -> no cmd_req, no error pulse, FSM back in S_IDLE. With UART_RX_MAJORITY_EN, a 1-clk low pulse mid-data-bit of 0xFF -> still 0xFF.
- rst_n low for 2 clks mid-data-bit and again while in H_REQ -> cmd_req=0, cmd_data=0 immediately; following 0x3C received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: frame shape, rx and handshake state codes.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        IDLE_LVL  = 1'b1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] H_IDLE  = 2'd0;
  localparam logic [1:0] H_REQ   = 2'd1;
  localparam logic [1:0] H_ACKLO = 2'd2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async rx line plus falling-edge detect.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_m_q, rx_s_q, rx_s_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q   <= IDLE_LVL;
      rx_s_q   <= IDLE_LVL;
      rx_s_d_q <= IDLE_LVL;
    end else begin
      rx_m_q   <= rx;
      rx_s_q   <= rx_m_q;
      rx_s_d_q <= rx_s_q;
    end
  end

  assign rx_s = rx_s_q;
  assign fall = rx_s_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver feeding a 4-phase cmd_req/cmd_ack handshake through a one-byte hold buffer.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around every sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_CLKS_PER_BIT = 100,
  parameter int P_CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       cmd_req,
  output logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam logic [P_CNT_W-1:0] CNT_ONE  = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] HALF_T   = P_CNT_W'(P_CLKS_PER_BIT / 2 - 1);
  localparam logic [P_CNT_W-1:0] FULL_T   = P_CNT_W'(P_CLKS_PER_BIT - 1);
  localparam logic [2:0]         LAST_IDX = 3'(DATA_BITS - 1);

  logic               rx_s, fall;
  logic [1:0]         state_q, state_d, h_state_q, h_state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d, tgt, cnt_rst;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shreg_q, shreg_d, hold_q, hold_d, cmd_data_q, cmd_data_d;
  logic               hold_vld_q, hold_vld_d, cmd_req_q, cmd_req_d;
  logic               frm_err_q, frm_err_d, ovr_err_q, ovr_err_d;
  logic               smp_at, smp_bit, byte_done, drain;

  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .rx(rx), .rx_s(rx_s), .fall(fall));

  assign tgt = (state_q == S_START) ? HALF_T : FULL_T;

`ifdef UART_RX_MAJORITY_EN
  // Votes taken at tgt-1 and tgt; decision at tgt+1, so cnt restarts at 1 to keep the bit period.
  logic m0_q, m0_d, m1_q, m1_d;
  assign m0_d    = (cnt_q == tgt - CNT_ONE) ? rx_s : m0_q;
  assign m1_d    = (cnt_q == tgt) ? rx_s : m1_q;
  assign smp_at  = (cnt_q == tgt + CNT_ONE);
  assign smp_bit = maj3(m0_q, m1_q, rx_s);
  assign cnt_rst = CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q <= IDLE_LVL;
      m1_q <= IDLE_LVL;
    end else begin
      m0_q <= m0_d;
      m1_q <= m1_d;
    end
  end
`else
  assign smp_at  = (cnt_q == tgt);
  assign smp_bit = rx_s;
  assign cnt_rst = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_ONE;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    frm_err_d = 1'b0;
    byte_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (smp_at) begin
          if (!smp_bit) begin
            cnt_d   = cnt_rst;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (smp_at) begin
          cnt_d          = cnt_rst;
          shreg_d[idx_q] = smp_bit;
          if (idx_q == LAST_IDX) state_d = S_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (smp_at) begin
          state_d   = S_IDLE;
          byte_done = smp_bit;
          frm_err_d = ~smp_bit;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A byte may land in hold on the same cycle the handshake drains it.
  assign drain = (h_state_q == H_IDLE) && hold_vld_q;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    ovr_err_d  = 1'b0;
    if (drain) hold_vld_d = 1'b0;
    if (byte_done) begin
      if (!hold_vld_q || drain) begin
        hold_d     = shreg_q;
        hold_vld_d = 1'b1;
      end else begin
        ovr_err_d  = 1'b1;
      end
    end
  end

  always_comb begin
    h_state_d  = h_state_q;
    cmd_req_d  = cmd_req_q;
    cmd_data_d = cmd_data_q;
    case (h_state_q)
      H_IDLE: begin
        if (hold_vld_q) begin
          cmd_data_d = hold_q;
          cmd_req_d  = 1'b1;
          h_state_d  = H_REQ;
        end
      end
      H_REQ: begin
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          h_state_d = H_ACKLO;
        end
      end
      H_ACKLO: begin
        if (!cmd_ack) h_state_d = H_IDLE;
      end
      default: h_state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      frm_err_q  <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      ovr_err_q  <= 1'b0;
      h_state_q  <= H_IDLE;
      cmd_req_q  <= 1'b0;
      cmd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      frm_err_q  <= frm_err_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      ovr_err_q  <= ovr_err_d;
      h_state_q  <= h_state_d;
      cmd_req_q  <= cmd_req_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign cmd_req  = cmd_req_q;
  assign cmd_data = cmd_data_q;
  assign frm_err  = frm_err_q;
  assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames/bursts against a queue model.
module tb_uart_rx;

  localparam int P = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif
  // Frame drop to cmd_req rise: stop-bit middle, +2 synchroniser, +2 hold/handshake.
  localparam int LAT = 9 * P + P / 2 + 4 + LAT_EXTRA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       cmd_ack = 1'b0;
  logic       cmd_req;
  logic [7:0] cmd_data;
  logic       frm_err, ovr_err;

  always #5 clk = ~clk;

  uart_rx #(.P_CLKS_PER_BIT(P), .P_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .cmd_req(cmd_req), .cmd_data(cmd_data),
    .cmd_ack(cmd_ack), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  int          errors = 0, checks = 0;
  int unsigned cyc = 0, start_cyc = 0, rise_cyc = 0;
  int          frm_cnt = 0, ovr_cnt = 0, rise_cnt = 0;
  int          base_frm = 0, base_ovr = 0, base_rise = 0;
  logic        req_prev = 1'b0;
  bit          ack_en = 1'b0;
  logic [7:0]  rcv_q[$];
  logic [7:0]  exp_q[$];
  int          occ = 0, exp_frm = 0, exp_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (ovr_err) ovr_cnt <= ovr_cnt + 1;
    if (cmd_req && !req_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    req_prev <= cmd_req;
  end

  // Consumer: 4-phase ack after 3 clocks, checking cmd_data holds from req rise through ack fall.
  initial begin
    logic [7:0] d;
    int n;
    forever begin
      @(negedge clk);
      if (ack_en && cmd_req && rst_n) begin
        d = cmd_data;
        rcv_q.push_back(d);
        repeat (3) @(negedge clk);
        chk("data_stable_req", 32'(cmd_data), 32'(d));
        cmd_ack = 1'b1;
        n = 0;
        while (cmd_req && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("req_drop_on_ack", 32'(cmd_req), 0);
        chk("data_stable_ack", 32'(cmd_data), 32'(d));
        cmd_ack = 1'b0;
        @(negedge clk);
        chk("data_stable_ackfall", 32'(cmd_data), 32'(d));
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    start_cyc = cyc;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < P; j++) begin
        rx = (k == gbit && j == P / 2) ? 1'b0 : fr[k];
        @(negedge clk);
      end
    rx = 1'b1;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)     exp_frm++;
    else if (occ < 2) begin
      exp_q.push_back(b);
      occ++;
    end else          exp_ovr++;
  endtask

  task automatic finish_scn(input string tag);
    int n;
    n = 0;
    ack_en = 1'b1;
    while (rcv_q.size() < exp_q.size() && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (4 * P) @(negedge clk);
    chk({tag, "_count"}, rcv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rcv_q.size()) chk({tag, "_byte"}, 32'(rcv_q[i]), 32'(exp_q[i]));
    chk({tag, "_frm_err"}, frm_cnt - base_frm, exp_frm);
    chk({tag, "_ovr_err"}, ovr_cnt - base_ovr, exp_ovr);
    rcv_q.delete();
    exp_q.delete();
    exp_frm  = 0;
    exp_ovr  = 0;
    occ      = 0;
    base_frm = frm_cnt;
    base_ovr = ovr_cnt;
    ack_en   = 1'b0;
  endtask

  task automatic send_checked(input logic [7:0] b, input logic stop_ok, input string tag);
    occ = 0;
    ack_en = 1'b1;
    base_rise = rise_cnt;
    send_frame(b, stop_ok, -1);
    model_frame(b, stop_ok);
    chk({tag, "_req_rises"}, rise_cnt - base_rise, stop_ok ? 1 : 0);
    if (stop_ok) chk({tag, "_req_latency"}, rise_cyc - start_cyc, LAT);
    repeat (P) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    int k, g;
    logic stop_ok;

    repeat (3) @(negedge clk);
    chk("rst_cmd_req", 32'(cmd_req), 0);
    chk("rst_cmd_data", 32'(cmd_data), 0);
    chk("rst_frm_err", 32'(frm_err), 0);
    chk("rst_ovr_err", 32'(ovr_err), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_checked(8'hA5, 1'b1, "a5");
    finish_scn("a5");

    foreach (exp_q[i]) exp_q.delete(i);
    send_frame(8'h8F, 1'b1, -1); model_frame(8'h8F, 1'b1);
    send_frame(8'hC7, 1'b1, -1); model_frame(8'hC7, 1'b1);
    finish_scn("two_deep");

    send_frame(8'h01, 1'b1, -1); model_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1, -1); model_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1, -1); model_frame(8'h03, 1'b1);
    finish_scn("overrun");

    send_checked(8'h55, 1'b0, "bad_stop");
    send_checked(8'h12, 1'b1, "after_bad");
    finish_scn("framing");

    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2 * P) @(negedge clk);
    finish_scn("short_low");
    send_checked(8'h6B, 1'b1, "after_short");
    finish_scn("after_short");

`ifdef UART_RX_MAJORITY_EN
    ack_en = 1'b1;
    send_frame(8'hFF, 1'b1, 3); model_frame(8'hFF, 1'b1);
    finish_scn("maj_glitch");
`endif

    send_frame(8'h5A, 1'b1, -1);
    rx = 1'b0;
    repeat (P) @(negedge clk);
    rx = 1'b1;
    repeat (P + P / 2) @(negedge clk);
    chk("rst1_req_before", 32'(cmd_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst1_cmd_req", 32'(cmd_req), 0);
    chk("rst1_cmd_data", 32'(cmd_data), 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'hC3, 1'b1, -1);
    repeat (4) @(negedge clk);
    chk("rst2_req_before", 32'(cmd_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_cmd_req", 32'(cmd_req), 0);
    chk("rst2_cmd_data", 32'(cmd_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_checked(8'h3C, 1'b1, "post_rst");
    finish_scn("post_rst");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(2, 4);
        ack_en = 1'b0;
        for (int j = 0; j < k; j++) begin
          b = 8'($urandom);
          send_frame(b, 1'b1, -1);
          model_frame(b, 1'b1);
        end
        finish_scn("rnd_burst");
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          g = $urandom_range(1, 5);
          rx = 1'b0;
          repeat (g) @(negedge clk);
          rx = 1'b1;
          repeat (2 * P) @(negedge clk);
        end
        repeat ($urandom_range(0, P)) @(negedge clk);
        b = 8'($urandom);
        stop_ok = ($urandom_range(0, 4) != 0);
        send_checked(b, stop_ok, "rnd_single");
        finish_scn("rnd_single");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
